// File: rtl/psg_pkg.sv
// Shared types and helpers for the PSG stereo mixer.
// Holds the stereo mode enum, mix/output widths, the per-CE mix and the 16-bit saturator.
package psg_pkg;

  localparam int MIX_W = 10;
  localparam int OUT_W = 16;
  localparam int DC_W  = 18;

  typedef enum logic [1:0] {
    MONO = 2'd0,
    ABC  = 2'd1,
    ACB  = 2'd2
  } stereo_mode_t;

  typedef struct packed {
    logic [MIX_W-1:0] l;
    logic [MIX_W-1:0] r;
  } mix_t;

  // Code 3 is not enumerated and falls back to mono.
  function automatic mix_t mix_lr(
    input logic [1:0] mode,
    input logic [7:0] a,
    input logic [7:0] b,
    input logic [7:0] c
  );
    logic [MIX_W-1:0] ea, eb, ec;
    mix_t m;
    ea = {2'b00, a};
    eb = {2'b00, b};
    ec = {2'b00, c};
    m.l = ea + eb + ec;
    m.r = ea + eb + ec;
    unique case (1'b1)
      (mode == ABC): begin
        m.l = (ea << 1) + eb;
        m.r = (ec << 1) + eb;
      end
      (mode == ACB): begin
        m.l = (ea << 1) + ec;
        m.r = (eb << 1) + ec;
      end
      default: ;
    endcase
    return m;
  endfunction

  function automatic logic [OUT_W-1:0] sat16(
    input logic signed [DC_W-1:0] v
  );
    logic [OUT_W-1:0] s;
    s = v[OUT_W-1:0];
    if (v[DC_W-1:OUT_W-1] != '0 &&
        v[DC_W-1:OUT_W-1] != '1) begin
      s = v[DC_W-1] ? 16'h8000 : 16'h7FFF;
    end
    return s;
  endfunction

endpackage

// File: rtl/psg_dc_blocker.sv
// One-pole DC blocker: y = x - x' + y' - (y' >>> 8), 18-bit math, 16-bit saturated.
// Ports: CLK, RESET (sync, high), in_valid, x[15:0] -> out_valid, y[15:0] (held).
module psg_dc_blocker
  import psg_pkg::*;
(
  input  logic             CLK,
  input  logic             RESET,
  input  logic             in_valid,
  input  logic [OUT_W-1:0] x,
  output logic             out_valid,
  output logic [OUT_W-1:0] y
);

  logic [OUT_W-1:0] xp_q, xp_d;
  logic [OUT_W-1:0] y_q, y_d;
  logic             ov_q, ov_d;

  logic signed [DC_W-1:0] xe, pe, ye, yn;

  assign xe = {{(DC_W-OUT_W){x[OUT_W-1]}}, x};
  assign pe = {{(DC_W-OUT_W){xp_q[OUT_W-1]}}, xp_q};
  assign ye = {{(DC_W-OUT_W){y_q[OUT_W-1]}}, y_q};
  assign yn = xe - pe + ye - (ye >>> 8);

  always_comb begin
    ov_d = in_valid;
    xp_d = xp_q;
    y_d  = y_q;
    if (in_valid) begin
      xp_d = x;
      y_d  = sat16(yn);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ov_q <= 1'b0;
      xp_q <= '0;
      y_q  <= '0;
    end else begin
      ov_q <= ov_d;
      xp_q <= xp_d;
      y_q  <= y_d;
    end
  end

  assign out_valid = ov_q;
  assign y         = y_q;

endmodule

// File: rtl/psg_stereo_mixer.sv
// Mixes three PSG channels to stereo, box-filters over 2**DECIM_LOG2 CEs, emits 16-bit L/R.
// Ports: CLK, RESET, CE, CH_A/B/C[7:0], STEREO_MODE[1:0] -> SAMPLE_VALID, LEFT, RIGHT.
// Option PSG_DC_BLOCK_EN adds a DC blocker per channel (one extra CLK of latency).
module psg_stereo_mixer
  import psg_pkg::*;
#(
  parameter int DECIM_LOG2 = 3
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CE,
  input  logic [7:0]       CH_A,
  input  logic [7:0]       CH_B,
  input  logic [7:0]       CH_C,
  input  logic [1:0]       STEREO_MODE,
  output logic             SAMPLE_VALID,
  output logic [OUT_W-1:0] LEFT,
  output logic [OUT_W-1:0] RIGHT
);

  localparam int AW  = MIX_W + DECIM_LOG2;
  // A 1-bit counter pinned at 0 covers DECIM_LOG2 = 0.
  localparam int CW  = (DECIM_LOG2 == 0) ? 1 : DECIM_LOG2;
  localparam logic [CW-1:0] LAST = CW'((1 << DECIM_LOG2) - 1);
  localparam int PAD = OUT_W - 1 - MIX_W;

  logic [AW-1:0]    acc_l_q, acc_l_d;
  logic [AW-1:0]    acc_r_q, acc_r_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             vld_q, vld_d;
  logic [OUT_W-1:0] xl_q, xl_d;
  logic [OUT_W-1:0] xr_q, xr_d;

  mix_t          mix;
  logic [AW-1:0] sum_l, sum_r;
  logic          last;

  assign mix   = mix_lr(STEREO_MODE, CH_A, CH_B, CH_C);
  assign sum_l = acc_l_q + AW'(mix.l);
  assign sum_r = acc_r_q + AW'(mix.r);
  assign last  = (cnt_q == LAST);

  always_comb begin
    acc_l_d = acc_l_q;
    acc_r_d = acc_r_q;
    cnt_d   = cnt_q;
    vld_d   = 1'b0;
    xl_d    = xl_q;
    xr_d    = xr_q;
    if (CE) begin
      vld_d   = last;
      cnt_d   = last ? '0 : cnt_q + CW'(1);
      acc_l_d = last ? '0 : sum_l;
      acc_r_d = last ? '0 : sum_r;
      // Top MIX_W bits of the window sum are the average.
      if (last) begin
        xl_d = {1'b0, sum_l[AW-1 -: MIX_W], {PAD{1'b0}}};
        xr_d = {1'b0, sum_r[AW-1 -: MIX_W], {PAD{1'b0}}};
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      acc_l_q <= '0;
      acc_r_q <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      xl_q    <= '0;
      xr_q    <= '0;
    end else begin
      acc_l_q <= acc_l_d;
      acc_r_q <= acc_r_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      xl_q    <= xl_d;
      xr_q    <= xr_d;
    end
  end

`ifdef PSG_DC_BLOCK_EN
  logic ov_l, ov_r;

  psg_dc_blocker u_dc_l (
    .CLK       (CLK),
    .RESET     (RESET),
    .in_valid  (vld_q),
    .x         (xl_q),
    .out_valid (ov_l),
    .y         (LEFT)
  );

  psg_dc_blocker u_dc_r (
    .CLK       (CLK),
    .RESET     (RESET),
    .in_valid  (vld_q),
    .x         (xr_q),
    .out_valid (ov_r),
    .y         (RIGHT)
  );

  assign SAMPLE_VALID = ov_l & ov_r;
`else
  assign SAMPLE_VALID = vld_q;
  assign LEFT         = xl_q;
  assign RIGHT        = xr_q;
`endif

endmodule
